// File: rtl/csa_pkg.sv
// Shared types and constants for the carry-save accumulator.
package csa_pkg;

    localparam int unsigned XLEN_DEF    = 49;
    localparam int unsigned MAX_NUM_OPS = 8;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        HOLD    = 2'd2
    } csa_state_e;

endpackage

// File: rtl/csa_tree.sv
// Combinational 3:2 compressor chain: folds NUM_OPS operands into a sum/carry pair.
module csa_tree
    import csa_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned NUM_OPS = 4
) (
    input  logic [NUM_OPS*XLEN-1:0] ops,
    input  logic [XLEN-1:0]         base_sum,
    input  logic [XLEN-1:0]         base_carry,
    output logic [XLEN-1:0]         sum_c,
    output logic [XLEN-1:0]         carry_c
);

    logic [XLEN-1:0] s_w [NUM_OPS+1];
    logic [XLEN-1:0] c_w [NUM_OPS+1];

    assign s_w[0] = base_sum;
    assign c_w[0] = base_carry;

    // One 3:2 row per operand; the carry is stored pre-shifted and its MSB dropped.
    for (genvar k = 0; k < NUM_OPS; k++) begin : g_row
        logic [XLEN-1:0] a_w;
        logic [XLEN-1:0] maj_w;
        assign a_w          = ops[k*XLEN +: XLEN];
        assign s_w[k+1]     = s_w[k] ^ c_w[k] ^ a_w;
        assign maj_w        = (s_w[k] & c_w[k]) | (s_w[k] & a_w) | (c_w[k] & a_w);
        assign c_w[k+1]     = {maj_w[XLEN-2:0], 1'b0};
    end

    assign sum_c   = s_w[NUM_OPS];
    assign carry_c = c_w[NUM_OPS];

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand carry-save accumulator with a single registered resolve add.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned NUM_OPS = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [NUM_OPS*XLEN-1:0] op_i,
    input  logic [NUM_OPS-1:0]      op_mask_i,
    input  logic                    clear_i,
    input  logic                    last_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         result_o,
    output logic [CNT_W-1:0]        beat_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    csa_state_e state_q, state_d;

    logic [XLEN-1:0]  sum_q, sum_d;
    logic [XLEN-1:0]  carry_q, carry_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic                    accept;
    logic                    handshake;
    logic [NUM_OPS*XLEN-1:0] masked_ops;
    logic [XLEN-1:0]         base_sum;
    logic [XLEN-1:0]         base_carry;
    logic [XLEN-1:0]         tree_sum;
    logic [XLEN-1:0]         tree_carry;

    // Masked-off operands enter the tree as zero.
    for (genvar k = 0; k < NUM_OPS; k++) begin : g_mask
        assign masked_ops[k*XLEN +: XLEN] = op_mask_i[k] ? op_i[k*XLEN +: XLEN] : '0;
    end

    assign base_sum   = clear_i ? '0 : sum_q;
    assign base_carry = clear_i ? '0 : carry_q;

    csa_tree #(
        .XLEN    (XLEN),
        .NUM_OPS (NUM_OPS)
    ) u_tree (
        .ops        (masked_ops),
        .base_sum   (base_sum),
        .base_carry (base_carry),
        .sum_c      (tree_sum),
        .carry_c    (tree_carry)
    );

    assign accept    = in_valid_i && (state_q == ACCUM);
    assign handshake = (state_q == HOLD) && out_valid_q && out_ready_i;

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        cnt_out_d = cnt_out_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    sum_d   = tree_sum;
                    carry_d = tree_carry;
                    if (clear_i)
                        cnt_d = CNT_W'(1);
                    else if (cnt_q != CNT_MAX)
                        cnt_d = cnt_q + CNT_W'(1);
                    if (last_i)
                        state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                result_d  = XLEN'(sum_q + carry_q);
                cnt_out_d = cnt_q;
                state_d   = HOLD;
            end
            HOLD: begin
                if (handshake) begin
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
        // Valid rises one cycle into HOLD so the result is registered before it is shown.
        out_valid_d = (state_q == HOLD) && !handshake;
        in_ready_d  = (state_d == ACCUM);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            carry_q     <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            cnt_out_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            cnt_out_q   <= cnt_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign beat_cnt_o  = cnt_out_q;

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Multi-operand carry-save accumulator for the MAC datapath. Each accepted beat carries up to NUM_OPS two's-complement operands. These are folded into a redundant sum/carry state through a row of 3:2 compressors, so no carry-propagate add occurs per beat. On the last beat of a sequence, a single registered carry-propagate add resolves the state to binary, and the result is held under a valid/ready handshake.

## Interface
- XLEN, 49, datapath width; all arithmetic is modulo 2^XLEN
- NUM_OPS, 4, operands per beat; legal range 1..8
- CNT_W, 16, width of the beat counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- in_valid_i  in  1  beat offered
- in_ready_o  out  1  beat accepted when in_valid_i && in_ready_o at a rising edge
- op_i  in  NUM_OPS*XLEN  operands, operand k at bits [k*XLEN +: XLEN], pre-sign-extended
- op_mask_i  in  NUM_OPS  bit k=1: operand k contributes; bit k=0: it is treated as zero
- clear_i  in  1  discard accumulated state before adding this beat
- last_i  in  1  final beat of sequence
- out_valid_o  out  1  result_o valid
- out_ready_i  in  1  consumer takes result
- result_o  out  XLEN  resolved sum
- beat_cnt_o  out  CNT_W  beats in the sequence that produced result_o; saturates at 2^CNT_W-1

## Operation
- State registers:
  - sum_q and carry_q, XLEN each. carry_q is stored already left-shifted by 1, and the bit shifted out of position XLEN-1 is dropped.
  - result_q, XLEN.
  - cnt_q, CNT_W.
  - fsm.
- FSM states: ACCUM, RESOLVE, HOLD.
  - ACCUM: in_ready_o=1. An accepted beat updates {sum_q, carry_q} ← reduce(masked ops, base_s, base_c), where base = 0 if clear_i else the current state. cnt_q ← (clear_i ? 1 : sat(cnt_q+1)). If last_i=1, go to RESOLVE.
  - RESOLVE: in_ready_o=0. result_q ← sum_q + carry_q mod 2^XLEN. beat_cnt_o is driven from cnt_q. Go to HOLD.
  - HOLD: in_ready_o=0, out_valid_o=1. result_o and beat_cnt_o are stable. On out_ready_i=1: sum_q, carry_q and cnt_q ← 0, then go to ACCUM.
- reduce(): NUM_OPS+2 vectors are compressed to 2 by NUM_OPS chained 3:2 rows. Each row's carry is shifted left 1, and the shifted-out bit is discarded.
- An all-zero op_mask_i is a legal beat: it adds zero but still counts as a beat.
- clear_i and last_i together produce a result equal to that beat's sum alone.
- in_valid_i while in_ready_o=0 is ignored. op_i is not sampled and no state changes.
- With no clear_i on the first beat after HOLD, accumulation starts from 0, because state is auto-cleared after output.

## Timing
- Reset values:
  - in_ready_o=1, out_valid_o=0.
  - result_o=0, beat_cnt_o=0.
  - sum_q, carry_q and cnt_q are 0; fsm is ACCUM.
- Reset mid-operation, in any state: all of the above apply at the next edge. Any pending result is lost.
- Per-beat throughput: 1 beat per cycle while in ACCUM.
- Latency: when the last beat is accepted at edge k, out_valid_o=1 after edge k+2 (RESOLVE occupies cycle k..k+1).
- Output handshake: out_valid_o=1 and out_ready_i=1 at edge m moves the FSM to ACCUM. in_ready_o=1 after edge m.
  - Minimum gap between the last beat of one sequence and the first beat of the next is 3 cycles.
- out_ready_i may be high before out_valid_o; it has no effect outside HOLD.
- out_valid_o never drops without a handshake, except on reset.

## Structure
- Shared package csa_pkg holds:
  - the FSM state enum (ACCUM, RESOLVE, HOLD);
  - the default XLEN constant 49;
  - the MAX_NUM_OPS constant 8.
- Sub-module csa_tree (parameters XLEN, NUM_OPS) is purely combinational: inputs are the masked operand bus and base sum/carry; outputs are the new sum/carry. It is built as a generate loop of 3:2 rows.
- csa_accumulator contains the FSM, the state registers, the CPA and the counter.

## Test plan
All scenarios use XLEN=49, NUM_OPS=4.
1. One beat with clear_i=last_i=1, op={4,3,2,1}, mask=1111 → out_valid_o rises 2 cycles after the handshake, result_o=10, beat_cnt_o=1.
2. Three beats, each op0=5, op1=7, mask=0011, last beat on #3 → result_o=36, beat_cnt_o=3. Ops 2/3 are set to garbage and must be ignored.
3. Wrap-around: op0=2^49-1, op1=2, mask=0011, last → result_o=1. Signed case: op0=2^49-5 (−5), op1=3 → result_o=2^49-2.
4. Backpressure: out_ready_i held low 5 cycles in HOLD while in_valid_i=1 with op0=99.
   - result_o stays stable and in_ready_o stays 0.
   - After the handshake, a new single-beat sequence op0=7 gives result_o=7.
5. Reset mid-sequence: 2 beats of op0=100, then rst_i pulsed for 1 cycle.
   - After reset: out_valid_o=0 and beat_cnt_o=0.
   - Next sequence op0=1 with last gives result_o=1.
6. Mid-sequence clear: beats op0=50, 60, then op0=8 with clear_i=1 and last_i=1 → result_o=8, beat_cnt_o=1.
